// File: rtl/seq_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_div_unit
// Function : Iterative signed/unsigned multiply and divide. Operands are
//            turned into magnitudes, processed one bit per cycle (shift-add
//            for multiply, restoring shift-subtract for divide), then
//            sign-corrected. Fixed latency for every operation.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Working registers. Multiply: r_acc_hi is the running partial product,
    // r_acc_lo starts as the multiplier and fills with product low bits.
    // Divide: r_acc_hi is the partial remainder, r_acc_lo starts as the
    // dividend and fills with quotient bits. r_mb is the multiplicand/divisor.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_mb;
    logic             r_is_div;
    logic             r_neg_q;     // product / quotient must be negated
    logic             r_neg_r;     // remainder must be negated
    logic             r_dz;        // divisor was zero for this operation

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    // Operand conditioning at start
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & opa[WIDTH-1];
    assign w_b_neg  = w_signed & opb[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude, so no extra bit is needed.
    assign w_mag_a  = w_a_neg ? -opa : opa;
    assign w_mag_b  = w_b_neg ? -opb : opb;

    // One multiply iteration: conditional add, then shift right with carry
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mb} : '0);
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    // One divide iteration: shift in next dividend bit, trial subtract.
    // The partial remainder is always below the divisor, so the shifted
    // value is below twice the divisor and bit WIDTH of the trial is a
    // reliable borrow flag.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_mb};

    // Select restored or subtracted remainder for the divide step
    always_comb begin
        w_div_hi = w_shift[WIDTH-1:0];
        w_div_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            w_div_hi = w_trial[WIDTH-1:0];
            w_div_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction of the finished magnitudes
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    // With a zero divisor the remainder magnitude equals |opa|, so restoring
    // the dividend sign returns opa unchanged (most-negative included).
    assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

    // Choose the final hi/lo pair for the operation type
    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = w_rem_fix;
            w_fix_lo = r_dz ? '1 : w_quo_fix;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_next_state = c_FIX;
            c_FIX:   w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != c_IDLE);
        done = (r_state == c_DONE);
    end

    // Datapath: operand capture, iteration, result write-back
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_mb       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        r_acc_lo <= op[1] ? w_mag_a : w_mag_b;
                        r_mb     <= op[1] ? w_mag_b : w_mag_a;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= op[1] & (opb == '0);
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc_hi <= w_div_hi;
                        r_acc_lo <= w_div_lo;
                    end else begin
                        r_acc_hi <= w_mul_hi;
                        r_acc_lo <= w_mul_lo;
                    end
                end
                c_FIX: begin
                    r_hi       <= w_fix_hi;
                    r_lo       <= w_fix_lo;
                    r_div_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_div_unit
// Function : Directed vector bench for seq_mul_div_unit at WIDTH=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;   // edges from start edge to done
    localparam int LIMIT = WIDTH + 10;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] MULU = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] DIVU = 2'b11;

    logic             clock = 1'b0;
    logic             clear;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  vop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation once the unit is idle; return edges until done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clock);
        while (busy) @(negedge clock);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clock); #1;
        start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{MUL,  32'h7FFFFFFF, 32'hFFFFFF9C, 32'hFFFFFFCE, 32'h00000064, 1'b0};
        vecs[1]  = '{MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{DIV,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{MULU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
        vecs[8]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[9]  = '{DIVU, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[12] = '{MUL,  32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[13] = '{DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
        vecs[14] = '{MULU, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0};
        vecs[15] = '{DIVU, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
        vecs[16] = '{DIV,  32'h80000000, 32'd2,        32'd0,        32'hC0000000, 1'b0};
        vecs[17] = '{DIVU, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0};

        clear = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        @(negedge clock);
        clear = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].vop, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(LAT));
            check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].ehi));
            check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].elo));
            check($sformatf("v%0d div_zero", i), 64'(div_zero), 64'(vecs[i].edz));
            check($sformatf("v%0d busy at done", i), 64'(busy), 64'd1);
        end

        // Start during DONE is ignored; results hold afterwards.
        do_op(DIVU, 32'd100, 32'd7, lat);
        start = 1'b1; op = MUL; opa = 32'd9; opb = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        check("done one-cycle", 64'(done), 64'd0);
        check("start in DONE ignored", 64'(busy), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("hold lo", 64'(lo), 64'd14);
        check("hold hi", 64'(hi), 64'd2);

        // Start mid-RUN is ignored: original operands complete.
        @(negedge clock);
        start = 1'b1; op = MULU; opa = 32'd1000; opb = 32'd1000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1; op = MULU; opa = 32'd2; opb = 32'd2;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < LIMIT) begin
            @(posedge clock); #1;
            lat++;
        end
        check("midrun latency", 64'(lat), 64'(LAT));
        check("midrun lo", 64'(lo), 64'd1000000);
        check("midrun hi", 64'(hi), 64'd0);

        // Abort with clear at iteration 10, after a spurious start mid-RUN.
        @(negedge clock);
        while (busy) @(negedge clock);
        start = 1'b1; op = MUL; opa = 32'h7FFFFFFF; opb = 32'hFFFFFF9C;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1; op = DIV; opa = 32'd50; opb = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        seen = 0;
        repeat (LIMIT) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        do_op(MUL, 32'h7FFFFFFF, 32'hFFFFFF9C, lat);
        check("post-abort latency", 64'(lat), 64'(LAT));
        check("post-abort hi", 64'(hi), 64'hFFFFFFCE);
        check("post-abort lo", 64'(lo), 64'h00000064);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
